// File: rtl/mac_issue_mult.sv
// Issue stage of the matrix-multiply datapath: walks (i,j,k) with k innermost,
// reads A/B from synchronous buffers and presents a registered product.
module mac_issue_mult #(
   parameter int M = 4,
   parameter int K = 4,
   parameter int N = 4,
   parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(M)-1:0]              addr_a_row,
   output logic [$clog2(K)-1:0]              addr_a_col,
   output logic [$clog2(K)-1:0]              addr_b_row,
   output logic [$clog2(N)-1:0]              addr_b_col,
   output logic                              re_ab,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0] data_a,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0] data_b,
   output logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
   output logic [$clog2(M)-1:0]              matrix_a_row_addr_counter_reg,
   output logic [$clog2(K)-1:0]              matrix_a_col_addr_counter_reg,
   output logic [$clog2(K)-1:0]              matrix_b_row_addr_counter_reg,
   output logic [$clog2(N)-1:0]              matrix_b_col_addr_counter_reg,
   output logic                              mult_done_reg
);

   localparam int MW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int NW = $clog2(N);
   localparam int W  = DATA_WIDTH_INIT_MATRIX;

   localparam logic [MW-1:0] I_LAST = MW'(M - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [NW-1:0] J_LAST = NW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_drain;

   logic [MW-1:0] r_i;
   logic [KW-1:0] r_k;
   logic [NW-1:0] r_j;

   logic          r_s1_v;
   logic [MW-1:0] r_s1_i;
   logic [KW-1:0] r_s1_k;
   logic [NW-1:0] r_s1_j;

   logic          w_run;
   logic          w_k_wrap;
   logic          w_j_wrap;
   logic          w_last;
   logic [2*W-1:0] w_prod;

   assign w_run    = (r_state == S_RUN);
   assign w_k_wrap = (r_k == K_LAST);
   assign w_j_wrap = (r_j == J_LAST);
   assign w_last   = w_run && w_k_wrap && w_j_wrap && (r_i == I_LAST);
   assign w_prod   = {{W{1'b0}}, data_a} * {{W{1'b0}}, data_b};

   assign re_ab      = w_run;
   assign addr_a_row = r_i;
   assign addr_a_col = r_k;
   assign addr_b_row = r_k;
   assign addr_b_col = r_j;

   // done marks the second drain cycle, when the final product is on the bus
   assign done = (r_state == S_DRAIN) && r_drain;
   assign busy = w_run || ((r_state == S_DRAIN) && !r_drain);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (start)   w_state_nxt = S_RUN;
         S_RUN:   if (w_last)  w_state_nxt = S_DRAIN;
         S_DRAIN: if (r_drain) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_drain <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= (r_state == S_DRAIN) ? !r_drain : 1'b0;
      end
   end

   // counters wrap back to zero on the last issue, so IDLE always sees (0,0,0)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_i <= '0;
         r_j <= '0;
         r_k <= '0;
      end else if (w_run) begin
         r_k <= w_k_wrap ? '0 : r_k + 1'b1;
         if (w_k_wrap) begin
            r_j <= w_j_wrap ? '0 : r_j + 1'b1;
            if (w_j_wrap)
               r_i <= (r_i == I_LAST) ? '0 : r_i + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_s1_v <= 1'b0;
         r_s1_i <= '0;
         r_s1_k <= '0;
         r_s1_j <= '0;
      end else begin
         r_s1_v <= w_run;
         r_s1_i <= r_i;
         r_s1_k <= r_k;
         r_s1_j <= r_j;
      end
   end

   // invalid cycles drive zeros so downstream never decodes a stale k=K-1
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mult_done_reg                 <= 1'b0;
         product_reg                   <= '0;
         matrix_a_row_addr_counter_reg <= '0;
         matrix_a_col_addr_counter_reg <= '0;
         matrix_b_row_addr_counter_reg <= '0;
         matrix_b_col_addr_counter_reg <= '0;
      end else begin
         mult_done_reg                 <= r_s1_v;
         product_reg                   <= r_s1_v ? w_prod : '0;
         matrix_a_row_addr_counter_reg <= r_s1_v ? r_s1_i : '0;
         matrix_a_col_addr_counter_reg <= r_s1_v ? r_s1_k : '0;
         matrix_b_row_addr_counter_reg <= r_s1_v ? r_s1_k : '0;
         matrix_b_col_addr_counter_reg <= r_s1_v ? r_s1_j : '0;
      end
   end

endmodule

// File: tb/tb_mac_issue_mult.sv
// Bench for mac_issue_mult: 2x2x2 table vectors plus 4x4x4 scoreboard passes.
module tb_mac_issue_mult;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- 4x4x4 instance ----------------
   logic        start;
   logic        busy, done, re_ab, mdone;
   logic [1:0]  ar, ac, br, bc;
   logic [31:0] da, db;
   logic [63:0] prod;
   logic [1:0]  ci, ck_a, ck_b, cj;
   logic [31:0] A4 [4][4];
   logic [31:0] B4 [4][4];

   mac_issue_mult dut (
      .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
      .addr_a_row(ar), .addr_a_col(ac), .addr_b_row(br), .addr_b_col(bc),
      .re_ab(re_ab), .data_a(da), .data_b(db), .product_reg(prod),
      .matrix_a_row_addr_counter_reg(ci), .matrix_a_col_addr_counter_reg(ck_a),
      .matrix_b_row_addr_counter_reg(ck_b), .matrix_b_col_addr_counter_reg(cj),
      .mult_done_reg(mdone)
   );

   always @(posedge clk) if (re_ab) begin
      da <= A4[ar][ac];
      db <= B4[br][bc];
   end

   // ---------------- 2x2x2 instance ----------------
   logic        start2;
   logic        busy2, done2, re2, mdone2;
   logic        ar2, ac2, br2, bc2;
   logic [31:0] da2, db2;
   logic [63:0] prod2;
   logic        ci2, cka2, ckb2, cj2;
   logic [31:0] A2 [2][2];
   logic [31:0] B2 [2][2];

   mac_issue_mult #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) dut2 (
      .clk(clk), .resetn(resetn), .start(start2), .busy(busy2), .done(done2),
      .addr_a_row(ar2), .addr_a_col(ac2), .addr_b_row(br2), .addr_b_col(bc2),
      .re_ab(re2), .data_a(da2), .data_b(db2), .product_reg(prod2),
      .matrix_a_row_addr_counter_reg(ci2), .matrix_a_col_addr_counter_reg(cka2),
      .matrix_b_row_addr_counter_reg(ckb2), .matrix_b_col_addr_counter_reg(cj2),
      .mult_done_reg(mdone2)
   );

   always @(posedge clk) if (re2) begin
      da2 <= A2[ar2][ac2];
      db2 <= B2[br2][bc2];
   end

   // ---------------- scoreboard + downstream model ----------------
   typedef struct {
      logic [1:0]  i, j, k;
      logic [63:0] p;
   } exp_t;

   exp_t        q[$];
   logic [63:0] C [4][4];
   int          n_valid = 0;
   int          n_done  = 0;
   bit          max_mode = 0;

   always @(negedge clk) begin
      exp_t e;
      if (done) n_done++;
      if (mdone) begin
         n_valid++;
         chk("a_col_eq_b_row", 64'(ck_a), 64'(ck_b));
         if (q.size() == 0) chk("unexpected_valid", 64'(mdone), 64'd0);
         else begin
            e = q.pop_front();
            chk("product", prod, e.p);
            chk("index_ijk", 64'({ci, cj, ck_a}), 64'({e.i, e.j, e.k}));
            if (max_mode) chk("max_product", prod, 64'hFFFF_FFFE_0000_0001);
            C[ci][cj] = C[ci][cj] + prod;
         end
      end else begin
         chk("idle_product_zero", prod, 64'd0);
         chk("idle_counters_zero", 64'({ci, ck_a, ck_b, cj}), 64'd0);
      end
   end

   task automatic load_expect();
      exp_t e;
      q.delete();
      n_valid = 0;
      n_done  = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            C[i][j] = '0;
            for (int k = 0; k < 4; k++) begin
               e.i = 2'(i); e.j = 2'(j); e.k = 2'(k);
               e.p = 64'(A4[i][k]) * 64'(B4[k][j]);
               q.push_back(e);
            end
         end
   endtask

   task automatic run_pass(input bit hold);
      int t0, tfirst, g, bad;
      logic [63:0] ref_c;
      load_expect();
      @(negedge clk); start = 1'b1; t0 = cyc;
      @(negedge clk); if (!hold) start = 1'b0;
      g = 0;
      while (!mdone && g < 10) begin @(negedge clk); g++; end
      chk("first_valid_seen", 64'(mdone), 64'd1);
      tfirst = cyc;
      chk("start_to_first_valid", 64'(tfirst - t0), 64'd3);
      g = 0;
      while (!done && g < 200) begin @(negedge clk); g++; end
      chk("done_seen", 64'(done), 64'd1);
      chk("valid_span", 64'(cyc - tfirst + 1), 64'd64);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("valid_count", 64'(n_valid), 64'd64);
      chk("done_count", 64'(n_done), 64'd1);
      chk("queue_empty", 64'(q.size()), 64'd0);
      chk("no_restart_busy", 64'(busy), 64'd0);
      bad = 0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            ref_c = '0;
            for (int k = 0; k < 4; k++) ref_c = ref_c + 64'(A4[i][k]) * 64'(B4[k][j]);
            if (C[i][j] !== ref_c) bad++;
         end
      chk("C_matches_ref", 64'(bad), 64'd0);
   endtask

   // ---------------- 2x2x2 vector table ----------------
   typedef struct {
      logic [2:0]  ijk;
      logic [63:0] p;
   } tv_t;

   tv_t tv[8];

   initial begin
      int g, t0, tlast;
      tv[0] = '{3'b000, 64'd5};  tv[1] = '{3'b001, 64'd14};
      tv[2] = '{3'b010, 64'd6};  tv[3] = '{3'b011, 64'd16};
      tv[4] = '{3'b100, 64'd15}; tv[5] = '{3'b101, 64'd28};
      tv[6] = '{3'b110, 64'd18}; tv[7] = '{3'b111, 64'd32};
      A2[0][0] = 1; A2[0][1] = 2; A2[1][0] = 3; A2[1][1] = 4;
      B2[0][0] = 5; B2[0][1] = 6; B2[1][0] = 7; B2[1][1] = 8;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            A4[i][j] = $urandom;
            B4[i][j] = $urandom;
         end

      resetn = 1'b0; start = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 64'({busy, done, re_ab, mdone}), 64'd0);
      chk("rst_addr", 64'({ar, ac, br, bc}), 64'd0);
      chk("rst_out", prod | 64'({ci, ck_a, ck_b, cj}), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // 2x2x2 known-answer pass
      start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      g = 0;
      while (!mdone2 && g < 10) begin
         if (re2) tlast = cyc;
         @(negedge clk); g++;
      end
      chk("t_first_valid_seen", 64'(mdone2), 64'd1);
      for (int n = 0; n < 8; n++) begin
         if (re2) tlast = cyc;
         chk("t_valid", 64'(mdone2), 64'd1);
         chk("t_product", prod2, tv[n].p);
         chk("t_ijk", 64'({ci2, cj2, cka2}), 64'(tv[n].ijk));
         chk("t_kmatch", 64'(cka2), 64'(ckb2));
         chk("t_done", 64'(done2), 64'(n == 7));
         chk("t_busy", 64'(busy2), 64'(n != 7));
         if (n < 7) @(negedge clk);
      end
      chk("t_done_after_last_issue", 64'(cyc - tlast), 64'd2);
      @(negedge clk);
      chk("t_idle_valid", 64'(mdone2), 64'd0);
      chk("t_idle_out", prod2 | 64'({ci2, cka2, ckb2, cj2, busy2, done2}), 64'd0);

      // 4x4x4 random pass, then start held high throughout a pass
      run_pass(1'b0);
      repeat (3) @(negedge clk);
      run_pass(1'b1);

      // reset at the 10th valid product
      load_expect();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      g = 0;
      while (n_valid < 10 && g < 40) begin @(negedge clk); g++; end
      chk("mid_reached_10", 64'(n_valid), 64'd10);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_ctrl", 64'({busy, done, re_ab, mdone}), 64'd0);
      chk("mid_rst_out", prod | 64'({ar, ac, br, bc, ci, ck_a, ck_b, cj}), 64'd0);
      repeat (2) @(negedge clk);
      chk("mid_rst_no_done", 64'(n_done), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      run_pass(1'b0);

      // all-ones operands: full 64-bit product, no truncation
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            A4[i][j] = 32'hFFFF_FFFF;
            B4[i][j] = 32'hFFFF_FFFF;
         end
      max_mode = 1'b1;
      run_pass(1'b0);
      max_mode = 1'b0;

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mac_issue_mult.md
Name: mac_issue_mult

Overview:
- Upstream stage of the accumulate/writeback stage of the matrix-multiply datapath.
- On start, walks every (i,j,k) index of C = A x B, with k innermost, then j, then i.
- For each index it reads A[i][k] and B[k][j] from synchronous-read buffers, multiplies them and presents a registered product plus aligned index counters and a valid strobe to the accumulator.
- Issues one product per cycle with a fixed 2-cycle pipeline.

Parameters:
- M, 4, rows of A and C (>=2)
- K, 4, cols of A / rows of B (>=2)
- N, 4, cols of B and C (>=2)
- DATA_WIDTH_INIT_MATRIX, 32, element width of A and B (unsigned)

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  begin a full matrix pass (sampled in IDLE only)
- busy  output  1  high from the cycle after accepted start until the cycle done pulses
- done  output  1  one-cycle pulse after the last product has been presented
- addr_a_row  output  $clog2(M)  A buffer row address (i)
- addr_a_col  output  $clog2(K)  A buffer col address (k)
- addr_b_row  output  $clog2(K)  B buffer row address (k)
- addr_b_col  output  $clog2(N)  B buffer col address (j)
- re_ab  output  1  read enable to both buffers
- data_a  input  DATA_WIDTH_INIT_MATRIX  A read data, valid 1 cycle after re_ab
- data_b  input  DATA_WIDTH_INIT_MATRIX  B read data, valid 1 cycle after re_ab
- product_reg  output  2*DATA_WIDTH_INIT_MATRIX  registered data_a*data_b
- matrix_a_row_addr_counter_reg  output  $clog2(M)  i aligned to product_reg
- matrix_a_col_addr_counter_reg  output  $clog2(K)  k aligned to product_reg
- matrix_b_row_addr_counter_reg  output  $clog2(K)  k aligned to product_reg
- matrix_b_col_addr_counter_reg  output  $clog2(N)  j aligned to product_reg
- mult_done_reg  output  1  product_reg and counters valid this cycle

Behaviour:
- Reset (async, resetn=0): FSM=IDLE. Every output is 0, including busy, done, re_ab, all addresses, product_reg, all *_counter_reg and mult_done_reg. Pipeline valid bits are cleared.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start=1. Counters i=j=k=0.
  - RUN: issues one index per cycle. re_ab=1 and addr_* = current (i,k,k,j).
  - Counter advance in RUN: k++. At k=K-1, k wraps to 0 and j++. At j=N-1, j wraps to 0 and i++.
  - RUN -> DRAIN in the cycle that issues (M-1,N-1,K-1). DRAIN lasts exactly 2 cycles with re_ab=0.
  - DRAIN -> IDLE after the last mult_done_reg. done=1 for that one cycle and busy drops in the same cycle.
- Pipeline:
  - Stage 1 (cycle t): address issue.
  - Stage 2 (t+1): data_a/data_b returned; indices delayed one register.
  - Stage 3 (t+2): product_reg <= data_a*data_b as full 2*W-bit unsigned, no truncation. Counters are aligned and mult_done_reg=1.
  - Latency from re_ab to mult_done_reg is exactly 2 cycles, with no bubbles inside a pass.
- A pass has exactly M*N*K cycles with mult_done_reg=1, and they are contiguous.
- matrix_a_col_addr_counter_reg always equals matrix_b_row_addr_counter_reg.
- When mult_done_reg=0, product_reg and all four *_counter_reg are driven to 0. This prevents the downstream stage from decoding a spurious k=K-1 write.
- start while busy=1 is ignored: no restart and no effect on counters.
- start is accepted in the same cycle that done pulses only if it is sampled in IDLE, i.e. the following cycle. A back-to-back pass therefore has a one-cycle gap minimum.
- Reset mid-pass: immediate return to IDLE with all outputs 0. No done pulse and no partial continuation. The next start begins at (0,0,0).
- Counters wrap naturally only at the defined terminal values. No index ever exceeds M-1, N-1 or K-1.

Test Plan:
- M=N=K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse -> products 5,14,6,16,15,28,18,32 on 8 contiguous mult_done_reg cycles. Counters (i,j,k) run (0,0,0),(0,0,1),(0,1,0)..(1,1,1). done is 2 cycles after the last issue.
- Default 4x4x4, with the bench checking the downstream model -> exactly 64 valid products. The first mult_done_reg is 3 cycles after start, since start is accepted to RUN in 1 cycle plus 2 cycles of latency. C equals the reference product.
- Assert start every cycle during a pass -> the pass completes unchanged, exactly one done, no restart.
- resetn low at the 10th valid product of a 4x4x4 pass -> all outputs 0 asynchronously and no done. A new start yields the full 64-product sequence from (0,0,0).
- A=B=all-ones of max value 2^32-1 -> product_reg = 0xFFFFFFFE00000001 on every valid cycle, with no truncation.
- Idle cycles and gaps between passes -> mult_done_reg=0 and all *_counter_reg=0 every such cycle.
